ram_shared_arbiter: RTL and testbench

- Shares one single-port SRAM between the core's instruction fetch port and its load/store port.
- Uses fixed data priority with a starvation limit that protects instruction fetch.
- Routes each one-cycle-latency RAM response back to the host that was granted.
- Decodes the memory window: out-of-range accesses get an error response and never reach the RAM.
- Sits between cve2_top and a 1-port RAM in the FPGA top level.

---
 rtl/ram_shared_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_shared_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_shared_arbiter.sv
// Shares one single-port SRAM between the instruction fetch and load/store ports.
// Data has fixed priority, bounded by a starvation limit that protects instruction fetch.
module ram_shared_arbiter #(
    parameter int unsigned MemSize     = 65536,
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter int unsigned StarveLimit = 4,
    localparam int unsigned RamAw      = $clog2(MemSize / 4)
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,

    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,

    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,

    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [RamAw-1:0] ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      ram_rdata_i
);

    localparam int unsigned     CntW     = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] LimitW   = CntW'(StarveLimit);
    localparam logic [31:0]     MemSizeW = 32'(MemSize);

    logic            active_q;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_data_q, rsp_data_d;
    logic            rsp_read_q, rsp_read_d;
    logic            rsp_err_q, rsp_err_d;

    logic            starved;
    logic            gnt_data, gnt_instr, gnt_any;
    logic [31:0]     sel_addr, offset;
    logic            in_range;

    // With StarveLimit = 0 the counter is always "starved", giving strict instr priority.
    assign starved   = (starve_cnt_q >= LimitW);
    assign gnt_data  = active_q & data_req_i & ~(instr_req_i & starved);
    assign gnt_instr = active_q & instr_req_i & ~gnt_data;
    assign gnt_any   = gnt_data | gnt_instr;

    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

    assign sel_addr = gnt_data ? data_addr_i : instr_addr_i;
    assign offset   = sel_addr - MemStart;
    assign in_range = (offset < MemSizeW);

    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (gnt_any && in_range) begin
            ram_req_o  = 1'b1;
            ram_addr_o = offset[RamAw+1:2];
            if (gnt_data) begin
                ram_we_o    = data_we_i;
                ram_be_o    = data_be_i;
                ram_wdata_o = data_wdata_i;
            end else begin
                ram_be_o = 4'hF;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!instr_req_i || gnt_instr) begin
            starve_cnt_d = '0;
        end else if (gnt_data && (starve_cnt_q < LimitW)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        rsp_valid_d = gnt_any;
        rsp_data_d  = gnt_data;
        rsp_read_d  = gnt_any & in_range & ~(gnt_data & data_we_i);
        rsp_err_d   = gnt_any & ~in_range;
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            active_q     <= 1'b0;
            starve_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 1'b0;
            rsp_read_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            active_q     <= 1'b1;
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_read_q   <= rsp_read_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // RAM read data is only forwarded to the owner of an in-range read.
    assign instr_rvalid_o = rsp_valid_q & ~rsp_data_q;
    assign data_rvalid_o  = rsp_valid_q & rsp_data_q;
    assign instr_err_o    = instr_rvalid_o & rsp_err_q;
    assign data_err_o     = data_rvalid_o & rsp_err_q;
    assign instr_rdata_o  = (instr_rvalid_o && rsp_read_q) ? ram_rdata_i : 32'h0;
    assign data_rdata_o   = (data_rvalid_o && rsp_read_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_shared_arbiter.sv
// Bench for ram_shared_arbiter: directed scenarios plus random traffic against a
// behavioural model of arbitration, address decode and the response pipeline.
module tb_ram_shared_arbiter;

    localparam int unsigned MEM_SIZE  = 65536;
    localparam logic [31:0] MEM_START = 32'h0000_0000;
    localparam int          LIMIT     = 4;
    localparam int          AW        = 14;
    localparam int          WORDS     = MEM_SIZE / 4;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    logic rst_sys_n = 1'b0;

    logic          instr_req_i = 1'b0;
    logic [31:0]   instr_addr_i = 32'h0;
    logic          instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]    data_be_i = 4'h0;
    logic [31:0]   data_addr_i = 32'h0, data_wdata_i = 32'h0;
    logic          data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0]   data_rdata_o;
    logic          ram_req_o, ram_we_o;
    logic [3:0]    ram_be_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i = 32'h0;

    ram_shared_arbiter #(.MemSize(MEM_SIZE), .MemStart(MEM_START), .StarveLimit(LIMIT)) u_dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    // Second instance with strict instruction priority.
    logic          s0_instr_req = 1'b0, s0_data_req = 1'b0;
    logic          s0_instr_gnt, s0_instr_rvalid, s0_instr_err;
    logic [31:0]   s0_instr_rdata;
    logic          s0_data_gnt, s0_data_rvalid, s0_data_err;
    logic [31:0]   s0_data_rdata;
    logic          s0_ram_req, s0_ram_we;
    logic [3:0]    s0_ram_be;
    logic [AW-1:0] s0_ram_addr;
    logic [31:0]   s0_ram_wdata;
    logic [31:0]   s0_ram_rdata = 32'h0;

    ram_shared_arbiter #(.MemSize(MEM_SIZE), .MemStart(MEM_START), .StarveLimit(0)) u_dut0 (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .instr_req_i(s0_instr_req), .instr_addr_i(32'h0000_0010), .instr_gnt_o(s0_instr_gnt),
        .instr_rvalid_o(s0_instr_rvalid), .instr_rdata_o(s0_instr_rdata), .instr_err_o(s0_instr_err),
        .data_req_i(s0_data_req), .data_we_i(1'b0), .data_be_i(4'hF),
        .data_addr_i(32'h0000_0020), .data_wdata_i(32'h0), .data_gnt_o(s0_data_gnt),
        .data_rvalid_o(s0_data_rvalid), .data_rdata_o(s0_data_rdata), .data_err_o(s0_data_err),
        .ram_req_o(s0_ram_req), .ram_we_o(s0_ram_we), .ram_be_o(s0_ram_be),
        .ram_addr_o(s0_ram_addr), .ram_wdata_o(s0_ram_wdata), .ram_rdata_i(s0_ram_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Environment RAM driven by the DUT's RAM port.
    logic [31:0] ram_mem [WORDS];
    always @(posedge clk_sys) begin
        if (ram_req_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o];
            end
        end
    end

    // Reference model: architectural memory, starvation count and one pending response.
    logic [31:0] ref_mem [WORDS];
    int          m_active = 0, m_starve = 0;
    bit          m_pv = 0, m_pd = 0, m_perr = 0;
    logic [31:0] m_prd = 32'h0;
    int          n_active = 0, n_starve = 0;
    bit          n_pv = 0, n_pd = 0, n_perr = 0;
    logic [31:0] n_prd = 32'h0;

    always @(posedge clk_sys) begin
        m_active = n_active;
        m_starve = n_starve;
        m_pv     = n_pv;
        m_pd     = n_pd;
        m_perr   = n_perr;
        m_prd    = n_prd;
    end

    always @(negedge clk_sys) begin : compare
        bit          gi, gd, ireq, dreq, inr, e_req, e_we, is_rd;
        logic [31:0] a, off, e_addr, e_wdata;
        logic [3:0]  e_be;
        int          idx;
        if (!rst_sys_n) begin
            gi = 0; gd = 0; e_req = 0; e_we = 0; e_be = 4'h0; e_addr = 0; e_wdata = 0;
            chk("rst_instr_rvalid", instr_rvalid_o, 0);
            chk("rst_data_rvalid", data_rvalid_o, 0);
            chk("rst_instr_rdata", instr_rdata_o, 0);
            chk("rst_data_rdata", data_rdata_o, 0);
            chk("rst_errs", {instr_err_o, data_err_o}, 0);
            n_active = 0; n_starve = 0; n_pv = 0; n_pd = 0; n_perr = 0; n_prd = 0;
        end else begin
            ireq = instr_req_i;
            dreq = data_req_i;
            gd   = (m_active != 0) && dreq && !(ireq && m_starve >= LIMIT);
            gi   = (m_active != 0) && ireq && !gd;
            a    = gd ? data_addr_i : instr_addr_i;
            off  = a - MEM_START;
            inr  = off < MEM_SIZE;
            idx  = int'(off >> 2);
            e_req   = (gi || gd) && inr;
            e_we    = e_req && gd && data_we_i;
            e_be    = e_req ? (gd ? data_be_i : 4'hF) : 4'h0;
            e_addr  = e_req ? (off >> 2) : 32'h0;
            e_wdata = (e_req && gd) ? data_wdata_i : 32'h0;
            is_rd   = !(gd && data_we_i);

            chk("instr_rvalid", instr_rvalid_o, m_pv && !m_pd);
            chk("data_rvalid", data_rvalid_o, m_pv && m_pd);
            chk("instr_err", instr_err_o, m_pv && !m_pd && m_perr);
            chk("data_err", data_err_o, m_pv && m_pd && m_perr);
            chk("instr_rdata", instr_rdata_o, (m_pv && !m_pd) ? m_prd : 32'h0);
            chk("data_rdata", data_rdata_o, (m_pv && m_pd) ? m_prd : 32'h0);

            n_pv   = gi || gd;
            n_pd   = gd;
            n_perr = (gi || gd) && !inr;
            n_prd  = (e_req && is_rd) ? ref_mem[idx] : 32'h0;
            if (e_we)
                for (int b = 0; b < 4; b++)
                    if (data_be_i[b]) ref_mem[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
            if (!ireq || gi)   n_starve = 0;
            else if (gd)       n_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else               n_starve = m_starve;
            n_active = 1;
        end
        chk("instr_gnt", instr_gnt_o, gi);
        chk("data_gnt", data_gnt_o, gd);
        chk("ram_req", ram_req_o, e_req);
        chk("ram_we", ram_we_o, e_we);
        chk("ram_be", ram_be_o, e_be);
        chk("ram_addr", ram_addr_o, e_addr);
        chk("ram_wdata", ram_wdata_o, e_wdata);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = 32'h0001_0000 + 32'($urandom_range(0, 1023));
            1:       a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            2:       a = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
            default: a = 32'($urandom_range(0, 1023));
        endcase
        return a;
    endfunction

    logic [8*12-1:0] pat;
    bit              gi_s, gd_s;

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            ref_mem[i] = ram_mem[i];
        end
        ram_mem['h20] = 32'hDEAD_BEEF; ref_mem['h20] = 32'hDEAD_BEEF;
        ram_mem['h40] = 32'hAAAA_BBBB; ref_mem['h40] = 32'hAAAA_BBBB;

        // Reset: outputs quiet even with a request pending.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0080;
        tick(); tick();
        @(negedge clk_sys);
        chk("reset_gnt", instr_gnt_o, 0);
        chk("reset_ram_req", ram_req_o, 0);
        tick();
        rst_sys_n = 1'b1;
        @(negedge clk_sys);
        chk("first_edge_gnt", instr_gnt_o, 0);

        // Instruction read of 0x80.
        tick();
        @(negedge clk_sys);
        chk("ifetch_gnt", instr_gnt_o, 1);
        chk("ifetch_ram_req", ram_req_o, 1);
        chk("ifetch_ram_addr", ram_addr_o, 32'h20);
        tick();
        idle();
        @(negedge clk_sys);
        chk("ifetch_rvalid", instr_rvalid_o, 1);
        chk("ifetch_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("ifetch_err", instr_err_o, 0);

        // Continuous contention: data wins four times, then instr once.
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h200;
        data_req_i  = 1'b1; data_addr_i  = 32'h400; data_we_i = 1'b0; data_be_i = 4'hF;
        pat = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_sys);
            gi_s = instr_gnt_o;
            gd_s = data_gnt_o;
            pat  = {pat[8*11-1:0], gi_s ? "I" : (gd_s ? "D" : "-")};
            tick();
            if (gi_s) instr_addr_i = instr_addr_i + 32'd4;
            if (gd_s) data_addr_i  = data_addr_i + 32'd4;
        end
        chk("starve_pattern", pat, "DDDDIDDDDIDD");
        idle();
        tick();

        // Partial write then read-back of 0x100.
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
        data_addr_i = 32'h100; data_wdata_i = 32'h1234_5678;
        @(negedge clk_sys);
        chk("wr_gnt", data_gnt_o, 1);
        chk("wr_ram_we", ram_we_o, 1);
        chk("wr_ram_be", ram_be_o, 4'h3);
        chk("wr_ram_addr", ram_addr_o, 32'h40);
        tick();
        data_we_i = 1'b0; data_be_i = 4'hF;
        @(negedge clk_sys);
        chk("wr_rvalid", data_rvalid_o, 1);
        chk("wr_err", data_err_o, 0);
        chk("rd_gnt", data_gnt_o, 1);
        tick();
        idle();
        @(negedge clk_sys);
        chk("rd_rvalid", data_rvalid_o, 1);
        chk("rd_rdata", data_rdata_o, 32'hAAAA_5678);

        // Out-of-range read just past the window.
        tick();
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0001_0000;
        @(negedge clk_sys);
        chk("oor_gnt", data_gnt_o, 1);
        chk("oor_ram_req", ram_req_o, 0);
        tick();
        idle();
        @(negedge clk_sys);
        chk("oor_rvalid", data_rvalid_o, 1);
        chk("oor_err", data_err_o, 1);
        chk("oor_rdata", data_rdata_o, 0);

        // Reset right after a grant discards the response.
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        @(negedge clk_sys);
        chk("midrst_gnt", instr_gnt_o, 1);
        tick();
        rst_sys_n = 1'b0;
        idle();
        @(negedge clk_sys);
        chk("midrst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        tick();
        rst_sys_n = 1'b1;
        @(negedge clk_sys);
        chk("midrst_after_release", {instr_rvalid_o, data_rvalid_o}, 0);
        tick(); tick();

        // Strict instruction priority instance.
        s0_instr_req = 1'b1;
        s0_data_req  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            chk("lim0_instr_gnt", s0_instr_gnt, 1);
            chk("lim0_data_gnt", s0_data_gnt, 0);
            tick();
        end
        s0_instr_req = 1'b0;
        @(negedge clk_sys);
        chk("lim0_data_after_drop", s0_data_gnt, 1);
        tick();
        s0_data_req = 1'b0;

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_sys);
            gi_s = instr_gnt_o;
            gd_s = data_gnt_o;
            tick();
            if (!rst_sys_n) begin
                rst_sys_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_sys_n = 1'b0;
                idle();
                continue;
            end
            if (!instr_req_i || gi_s) begin
                instr_req_i  = ($urandom_range(0, 3) != 0);
                instr_addr_i = rand_addr();
            end
            if (!data_req_i || gd_s) begin
                data_req_i   = ($urandom_range(0, 2) != 0);
                data_we_i    = $urandom_range(0, 1) == 1;
                data_be_i    = 4'($urandom_range(0, 15));
                data_addr_i  = rand_addr();
                data_wdata_i = $urandom;
            end
        end
        idle();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
